// File: rtl/axi_lrsc_pkg.sv
// Shared types for the LR/SC reservation controller: command opcodes,
// controller states and the statistics counter width.
package axi_lrsc_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_LR    = 2'b01,
    OP_SC    = 2'b10,
    OP_READ  = 2'b11
  } lrsc_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    CHECK,
    CLR,
    RSP
  } lrsc_state_e;

  localparam int unsigned CNT_WIDTH = 16;

endpackage

// File: rtl/axi_lrsc_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module axi_lrsc_sat_cnt
  import axi_lrsc_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_lrsc_ctrl.sv
// LR/SC reservation controller: serialises one command at a time against an
// external reservation table. Define AXI_LRSC_STATS_EN to build SC counters.
module axi_lrsc_ctrl
  import axi_lrsc_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id_i,
  output logic [AXI_ADDR_WIDTH-1:0] clr_addr_o,
  output logic                      clr_req_o,
  input  logic                      clr_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0] set_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   set_id_o,
  output logic                      set_req_o,
  input  logic                      set_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0] check_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   check_id_o,
  output logic                      check_req_o,
  input  logic                      check_gnt_i,
  input  logic                      check_res_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   rsp_id_o,
  output logic                      rsp_ok_o,
  output logic [CNT_WIDTH-1:0]      sc_ok_cnt_o,
  output logic [CNT_WIDTH-1:0]      sc_fail_cnt_o
);

  if (AXI_ADDR_WIDTH == 0 || AXI_ID_WIDTH == 0) begin : g_bad_param
    $fatal(1, "axi_lrsc_ctrl: AXI_ADDR_WIDTH and AXI_ID_WIDTH must be non-zero");
  end

  lrsc_state_e               state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      cmd_ready_q;
  logic                      set_req_q;
  logic                      check_req_q;
  logic                      clr_req_q;
  logic                      rsp_valid_q;
  logic                      rsp_ok_q;

  // All outputs are registered; a grant is consumed in the cycle it is seen
  // and the next request or response appears on the following edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      id_q        <= '0;
      cmd_ready_q <= 1'b1;
      set_req_q   <= 1'b0;
      check_req_q <= 1'b0;
      clr_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            addr_q      <= cmd_addr_i;
            id_q        <= cmd_id_i;
            cmd_ready_q <= 1'b0;
            case (lrsc_op_e'(cmd_op_i))
              OP_LR: begin
                state_q   <= SET;
                set_req_q <= 1'b1;
              end
              OP_SC: begin
                state_q     <= CHECK;
                check_req_q <= 1'b1;
              end
              OP_WRITE: begin
                state_q   <= CLR;
                clr_req_q <= 1'b1;
              end
              default: begin
                state_q     <= RSP;
                rsp_valid_q <= 1'b1;
                rsp_ok_q    <= 1'b1;
              end
            endcase
          end
        end
        SET: begin
          if (set_gnt_i) begin
            state_q     <= RSP;
            set_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_ok_q    <= 1'b1;
          end
        end
        CHECK: begin
          // A live reservation means the SC wins and must consume it.
          if (check_gnt_i) begin
            check_req_q <= 1'b0;
            if (check_res_i) begin
              state_q   <= CLR;
              clr_req_q <= 1'b1;
            end else begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_ok_q    <= 1'b0;
            end
          end
        end
        CLR: begin
          if (clr_gnt_i) begin
            state_q     <= RSP;
            clr_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_ok_q    <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign set_req_o    = set_req_q;
  assign check_req_o  = check_req_q;
  assign clr_req_o    = clr_req_q;
  assign set_addr_o   = addr_q;
  assign check_addr_o = addr_q;
  assign clr_addr_o   = addr_q;
  assign set_id_o     = id_q;
  assign check_id_o   = id_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_ok_o     = rsp_ok_q;
  assign rsp_id_o     = id_q;

`ifdef AXI_LRSC_STATS_EN
  logic sc_q;
  logic rsp_hs;
  logic sc_ok_inc;
  logic sc_fail_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_q <= 1'b0;
    end else if (cmd_valid_i && cmd_ready_q) begin
      sc_q <= (lrsc_op_e'(cmd_op_i) == OP_SC);
    end
  end

  // SC outcomes are counted when the response is actually taken.
  assign rsp_hs      = rsp_valid_q && rsp_ready_i;
  assign sc_ok_inc   = rsp_hs && sc_q && rsp_ok_q;
  assign sc_fail_inc = rsp_hs && sc_q && !rsp_ok_q;

  axi_lrsc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (sc_ok_inc),
    .cnt_o (sc_ok_cnt_o)
  );

  axi_lrsc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_fail_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (sc_fail_inc),
    .cnt_o (sc_fail_cnt_o)
  );
`else
  assign sc_ok_cnt_o   = '0;
  assign sc_fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_lrsc_ctrl.sv
// Scoreboard bench for axi_lrsc_ctrl: a reservation-table model predicts each
// response, a monitor checks responses, request protocol and SC counters.
`timescale 1ns/1ps
module tb_axi_lrsc_ctrl;
  import axi_lrsc_pkg::*;

  localparam int AW = 64;
  localparam int IW = 4;

  logic          clk_i;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [AW-1:0] cmd_addr_i;
  logic [IW-1:0] cmd_id_i;
  logic [AW-1:0] clr_addr_o;
  logic          clr_req_o;
  logic          clr_gnt_i;
  logic [AW-1:0] set_addr_o;
  logic [IW-1:0] set_id_o;
  logic          set_req_o;
  logic          set_gnt_i;
  logic [AW-1:0] check_addr_o;
  logic [IW-1:0] check_id_o;
  logic          check_req_o;
  logic          check_gnt_i;
  logic          check_res_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [IW-1:0] rsp_id_o;
  logic          rsp_ok_o;
  logic [15:0]   sc_ok_cnt_o;
  logic [15:0]   sc_fail_cnt_o;

  axi_lrsc_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_id_i(cmd_id_i),
    .clr_addr_o(clr_addr_o), .clr_req_o(clr_req_o), .clr_gnt_i(clr_gnt_i),
    .set_addr_o(set_addr_o), .set_id_o(set_id_o), .set_req_o(set_req_o), .set_gnt_i(set_gnt_i),
    .check_addr_o(check_addr_o), .check_id_o(check_id_o), .check_req_o(check_req_o),
    .check_gnt_i(check_gnt_i), .check_res_i(check_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o), .rsp_ok_o(rsp_ok_o),
    .sc_ok_cnt_o(sc_ok_cnt_o), .sc_fail_cnt_o(sc_fail_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          ok;
    logic          isSc;
  } exp_t;

  exp_t expQ[$];

  int total = 0;
  int bad   = 0;

  // Reference reservations (model) and the table seen through DUT ports.
  bit            mValid[8];
  logic [IW-1:0] mId[8];
  bit            tblValid[8];
  logic [IW-1:0] tblId[8];
  int            okCnt = 0;
  int            failCnt = 0;

  int            gntMode;
  bit            monOn;
  logic [1:0]    curOp;
  logic [AW-1:0] curAddr;
  logic [IW-1:0] curId;
  logic          curExpOk;

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[14:12]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one command; the model decides the answer at acceptance time.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                               input logic [IW-1:0] id, input bit expectRsp);
    int  waitCnt;
    int  i;
    logic ok;
    waitCnt = 0;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_id_i    = id;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && waitCnt < 200) begin
      @(posedge clk_i); #1;
      waitCnt++;
    end
    checkOutput("cmd_accept_in_time", (waitCnt < 200), 1);
    i = idx(addr);
    ok = 1'b1;
    case (op)
      OP_LR:    begin mValid[i] = 1'b1; mId[i] = id; end
      OP_SC:    begin ok = mValid[i] && (mId[i] == id); if (ok) mValid[i] = 1'b0; end
      OP_WRITE: mValid[i] = 1'b0;
      default:  ok = 1'b1;
    endcase
    curOp = op; curAddr = addr; curId = id; curExpOk = ok;
    if (expectRsp) expQ.push_back('{id: id, ok: ok, isSc: (op == OP_SC)});
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic runLatency(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [IW-1:0] id, input int expLat);
    int lat;
    applyStimulus(op, addr, id, 1'b1);
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    checkOutput("rsp_latency", lat, expLat);
  endtask

  // Environment: grants, response ready and the reservation table itself.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      case (gntMode)
        0: begin
          set_gnt_i   = ($urandom % 2) == 0;
          check_gnt_i = ($urandom % 2) == 0;
          clr_gnt_i   = ($urandom % 3) == 0;
          rsp_ready_i = ($urandom % 3) != 0;
        end
        1: begin
          set_gnt_i = 1'b0; check_gnt_i = 1'b0; clr_gnt_i = 1'b0; rsp_ready_i = 1'b1;
        end
        default: begin
          set_gnt_i = 1'b1; check_gnt_i = 1'b1; clr_gnt_i = 1'b1; rsp_ready_i = 1'b1;
        end
      endcase
      check_res_i = tblValid[idx(check_addr_o)] && (tblId[idx(check_addr_o)] == check_id_o);
      if (!rst_i) begin
        if (set_req_o && set_gnt_i) begin
          tblValid[idx(set_addr_o)] = 1'b1;
          tblId[idx(set_addr_o)]    = set_id_o;
        end
        if (clr_req_o && clr_gnt_i) tblValid[idx(clr_addr_o)] = 1'b0;
      end
    end
  end

  // Monitor: protocol invariants, response scoreboard, counters.
  logic [2:0]    kind, prevKind;
  logic [AW-1:0] reqAddr, prevAddr;
  logic          prevHeld, prevRspHeld, prevOk, cntPending, reqGnt, allowed;
  logic [IW-1:0] prevRspId;
  exp_t          got;

  initial begin
    prevHeld = 0; prevRspHeld = 0; cntPending = 0;
    forever begin
      @(negedge clk_i);
      if (!monOn || rst_i) begin
        prevHeld = 0; prevRspHeld = 0; cntPending = 0;
      end else begin
        kind = {set_req_o, check_req_o, clr_req_o};
        reqAddr = set_req_o ? set_addr_o : (check_req_o ? check_addr_o : clr_addr_o);
        checkOutput("req_onehot", ($countones(kind) <= 1), 1);
        if (kind != 3'b000) begin
          checkOutput("req_addr", reqAddr, curAddr);
          if (set_req_o) checkOutput("set_id", set_id_o, curId);
          if (check_req_o) checkOutput("check_id", check_id_o, curId);
          allowed = (kind == 3'b100 && curOp == OP_LR) ||
                    (kind == 3'b010 && curOp == OP_SC) ||
                    (kind == 3'b001 && (curOp == OP_WRITE || (curOp == OP_SC && curExpOk)));
          checkOutput("req_kind", allowed, 1);
        end
        if (prevHeld) begin
          checkOutput("req_hold_kind", kind, prevKind);
          checkOutput("req_hold_addr", reqAddr, prevAddr);
        end
        reqGnt = (set_req_o && set_gnt_i) || (check_req_o && check_gnt_i) || (clr_req_o && clr_gnt_i);
        prevHeld = (kind != 3'b000) && !reqGnt;
        prevKind = kind;
        prevAddr = reqAddr;

        if (rsp_valid_o) checkOutput("cmd_ready_low_in_rsp", cmd_ready_o, 0);
        if (prevRspHeld) begin
          checkOutput("rsp_hold_valid", rsp_valid_o, 1);
          checkOutput("rsp_hold_id", rsp_id_o, prevRspId);
          checkOutput("rsp_hold_ok", rsp_ok_o, prevOk);
        end
        prevRspHeld = rsp_valid_o && !rsp_ready_i;
        prevRspId = rsp_id_o;
        prevOk = rsp_ok_o;

        if (cntPending) begin
`ifdef AXI_LRSC_STATS_EN
          checkOutput("sc_ok_cnt", sc_ok_cnt_o, okCnt);
          checkOutput("sc_fail_cnt", sc_fail_cnt_o, failCnt);
`else
          checkOutput("sc_ok_cnt", sc_ok_cnt_o, 0);
          checkOutput("sc_fail_cnt", sc_fail_cnt_o, 0);
`endif
          cntPending = 0;
        end

        if (rsp_valid_o && rsp_ready_i) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 1, 0);
          end else begin
            got = expQ.pop_front();
            checkOutput("rsp_id", rsp_id_o, got.id);
            checkOutput("rsp_ok", rsp_ok_o, got.ok);
            if (got.isSc) begin
              if (got.ok) begin if (okCnt < 65535) okCnt++; end
              else begin if (failCnt < 65535) failCnt++; end
            end
            cntPending = 1;
          end
        end
      end
    end
  end

  initial begin
    int drain;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    for (int i = 0; i < 8; i++) begin mValid[i] = 0; tblValid[i] = 0; mId[i] = '0; tblId[i] = '0; end
    rst_i = 1'b1; cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = '0; cmd_id_i = '0;
    set_gnt_i = 0; check_gnt_i = 0; clr_gnt_i = 0; check_res_i = 0; rsp_ready_i = 0;
    gntMode = 1; monOn = 0;
    curOp = OP_READ; curAddr = '0; curId = '0; curExpOk = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_reqs", {set_req_o, check_req_o, clr_req_o}, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_ok", rsp_ok_o, 0);
    checkOutput("rst_rsp_id", rsp_id_o, 0);
    checkOutput("rst_set_addr", set_addr_o, 0);
    checkOutput("rst_check_addr", check_addr_o, 0);
    checkOutput("rst_clr_addr", clr_addr_o, 0);
    checkOutput("rst_ids", {set_id_o, check_id_o}, 0);
    checkOutput("rst_counters", {sc_ok_cnt_o, sc_fail_cnt_o}, 0);
    monOn = 1;

    // Reset while an SC waits for its check grant: nothing may come back.
    @(posedge clk_i); #1;
    applyStimulus(OP_SC, 64'h3000, 4'd2, 1'b0);
    repeat (2) begin @(posedge clk_i); #1; end
    checkOutput("check_req_waiting", check_req_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checkOutput("rst_mid_check_req", check_req_o, 0);
    checkOutput("rst_mid_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_mid_rsp_valid", rsp_valid_o, 0);
    repeat (3) begin @(posedge clk_i); #1; end

    // Directed scenarios with grants tied high to expose minimum latency.
    gntMode = 2;
    @(posedge clk_i); #1;
    runLatency(OP_LR,    64'h1000, 4'd3, 2);
    runLatency(OP_SC,    64'h1000, 4'd3, 3);
    runLatency(OP_SC,    64'h2000, 4'd5, 2);
    runLatency(OP_READ,  64'h4000, 4'd1, 1);
    runLatency(OP_WRITE, 64'h1000, 4'd7, 2);
    runLatency(OP_LR,    64'h2000, 4'd6, 2);
    runLatency(OP_SC,    64'h2000, 4'd5, 2);

    // Randomised traffic with random grants and backpressure.
    gntMode = 0;
    for (int n = 0; n < 300; n++) begin
      op   = 2'($urandom % 4);
      addr = 64'(($urandom % 4) + 1) << 12;
      id   = 4'($urandom % 3);
      applyStimulus(op, addr, id, 1'b1);
      if (($urandom % 4) == 0) begin @(posedge clk_i); #1; end
    end

    gntMode = 2;
    drain = 0;
    while ((expQ.size() != 0 || !cmd_ready_o) && drain < 200) begin
      @(posedge clk_i); #1;
      drain++;
    end
    checkOutput("queue_drained", expQ.size(), 0);
    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
